dmem_responder: RTL and testbench

Data-side memory responder that terminates the single-cycle CPU's data port (daddr/dwdata/dwe → drdata).
- Serves a byte-lane-writable RAM region.
- Serves an MMIO region with a 64-bit cycle counter, a scratch register and a byte TX FIFO.
- The TX FIFO drains to a valid/ready stream; top level connects it to a UART or testbench sink.
- Reads are combinational, as the single-cycle CPU requires. Writes commit on the clock edge.

---
 rtl/dmem_responder_pkg.sv | 21 ++
 rtl/dmem_responder_byte_fifo.sv | 57 +++++
 rtl/dmem_responder.sv | 142 ++++++++++++++
 tb/tb_dmem_responder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-side memory responder: MMIO word offsets,
// STATUS register bit positions and the region-select address bit.
package dmem_pkg;

  // Address bit that selects the MMIO region over RAM
  localparam int MMIO_SEL = 31;

  // MMIO register word offsets (daddr[7:2])
  localparam logic [5:0] OFF_CYCLE_LO = 6'h00;
  localparam logic [5:0] OFF_CYCLE_HI = 6'h01;
  localparam logic [5:0] OFF_TX_DATA  = 6'h02;
  localparam logic [5:0] OFF_STATUS   = 6'h03;
  localparam logic [5:0] OFF_SCRATCH  = 6'h04;

  // STATUS register bit positions
  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_COUNT_LSB = 4;

endpackage

// File: rtl/dmem_responder_byte_fifo.sv
// Byte-wide circular TX FIFO. A push while full is accepted only when a pop
// frees a slot in the same cycle; otherwise it is dropped and flagged.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               head,
  output logic                     overflow_pulse
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]    store [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full           = (count == (PW+1)'(DEPTH));
  assign empty          = (count == '0);
  assign do_pop         = pop & ~empty;
  assign do_push        = push & (~full | do_pop);
  assign overflow_pulse = push & full & ~do_pop;
  assign head           = empty ? 8'h00 : store[rd_ptr];

  // Entry storage: written on accepted push, never cleared
  always_ff @(posedge clk) begin
    if (do_push) begin
      store[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-port responder for the single-cycle CPU: byte-lane RAM plus an MMIO
// block with a 64-bit cycle counter, a scratch register and a TX byte FIFO.
// Reads are combinational from pre-edge state; writes commit on the edge.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int MEM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwe,
  output logic [31:0] drdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   mem [MEM_WORDS];
  logic [63:0]   cycle_q;
  logic [31:0]   scratch_q;
  logic          overflow_q;

  logic          is_mmio;
  logic [AW-1:0] ram_idx;
  logic [5:0]    mmio_off;
  logic [4:0]    shamt;
  logic [31:0]   wdata_sh;
  logic [3:0]    wmask_sh;
  logic          ram_we;
  logic          mmio_we;
  logic          fifo_push;
  logic          fifo_pop;
  logic          ovf_clear;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_head;
  logic          fifo_ovf_pulse;
  logic [31:0]   status_word;
  logic [31:0]   word;
  logic          unused_addr_bits;

  // Region decode and lane alignment; lanes shifted past bit 31 are dropped
  assign is_mmio   = daddr[MMIO_SEL];
  assign ram_idx   = daddr[AW+1:2];
  assign mmio_off  = daddr[7:2];
  assign shamt     = {daddr[1:0], 3'b000};
  assign wdata_sh  = dwdata << shamt;
  assign wmask_sh  = dwe << daddr[1:0];

  assign ram_we    = ~reset & ~is_mmio;
  assign mmio_we   = ~reset & is_mmio;
  assign fifo_push = mmio_we & (mmio_off == OFF_TX_DATA) & wmask_sh[0];
  assign ovf_clear = mmio_we & (mmio_off == OFF_STATUS) & wmask_sh[0] & wdata_sh[ST_OVF];
  assign fifo_pop  = tx_valid & tx_ready;

  assign tx_valid  = ~fifo_empty;
  assign tx_data   = fifo_head;

  assign unused_addr_bits = ^daddr[30:8];

  byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk           (clk),
    .reset         (reset),
    .push          (fifo_push),
    .push_data     (wdata_sh[7:0]),
    .pop           (fifo_pop),
    .full          (fifo_full),
    .empty         (fifo_empty),
    .count         (fifo_count),
    .head          (fifo_head),
    .overflow_pulse(fifo_ovf_pulse)
  );

  // RAM lane writes; contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int l = 0; l < 4; l++) begin
        if (wmask_sh[l]) mem[ram_idx][8*l +: 8] <= wdata_sh[8*l +: 8];
      end
    end
  end

  // Free-running 64-bit cycle counter
  always_ff @(posedge clk) begin
    if (reset) cycle_q <= '0;
    else       cycle_q <= cycle_q + 64'd1;
  end

  // SCRATCH register with byte-masked writes
  always_ff @(posedge clk) begin
    if (reset) begin
      scratch_q <= '0;
    end else if (mmio_we && mmio_off == OFF_SCRATCH) begin
      for (int l = 0; l < 4; l++) begin
        if (wmask_sh[l]) scratch_q[8*l +: 8] <= wdata_sh[8*l +: 8];
      end
    end
  end

  // Sticky overflow flag; a new overflow beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset)               overflow_q <= 1'b0;
    else if (fifo_ovf_pulse) overflow_q <= 1'b1;
    else if (ovf_clear)      overflow_q <= 1'b0;
  end

  // STATUS register assembly
  always_comb begin
    status_word                        = '0;
    status_word[ST_FULL]               = fifo_full;
    status_word[ST_EMPTY]              = fifo_empty;
    status_word[ST_OVF]                = overflow_q;
    status_word[ST_COUNT_LSB +: CW]    = fifo_count;
  end

  // Read mux: pick the addressed word, then right-align it to the byte offset
  always_comb begin
    word = '0;
    if (is_mmio) begin
      case (mmio_off)
        OFF_CYCLE_LO: word = cycle_q[31:0];
        OFF_CYCLE_HI: word = cycle_q[63:32];
        OFF_STATUS:   word = status_word;
        OFF_SCRATCH:  word = scratch_q;
        default:      word = '0;
      endcase
    end else begin
      word = mem[ram_idx];
    end
    drdata = word >> shamt;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, hand-written FIFO and
// reset sequences, then randomized traffic against a behavioural model.
module tb_dmem_responder;

  localparam int MEM_WORDS  = 1024;
  localparam int FIFO_DEPTH = 8;

  localparam logic [31:0] A_LO = 32'h8000_0000;
  localparam logic [31:0] A_HI = 32'h8000_0004;
  localparam logic [31:0] A_TX = 32'h8000_0008;
  localparam logic [31:0] A_ST = 32'h8000_000C;
  localparam logic [31:0] A_SC = 32'h8000_0010;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dwe;
  logic [31:0] drdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  we;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [18];

  // Behavioural model state for the random phase
  logic [31:0] mram [16];
  logic [31:0] mscr;
  logic [7:0]  mq [$];
  logic        movf;
  logic [63:0] mcnt;

  always #10 clk = ~clk;

  dmem_responder #(
    .MEM_WORDS (MEM_WORDS),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .daddr   (daddr),
    .dwdata  (dwdata),
    .dwe     (dwe),
    .drdata  (drdata),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .tx_ready(tx_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic apply(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w, input logic r);
    daddr = a; dwdata = d; dwe = w; tx_ready = r;
    #1;
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic rd(input logic [31:0] a, input string name, input logic [31:0] exp);
    daddr = a; dwe = 4'h0;
    #1;
    chk(name, drdata, exp);
  endtask

  task automatic fill(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      apply(A_TX, 32'(first + 8'(i)), 4'b0001, 1'b0);
      tick;
    end
  endtask

  initial begin
    reset = 1'b1;
    daddr = '0; dwdata = '0; dwe = '0; tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Counter starts at 0 right after reset, then counts cycles
    rd(A_LO, "cnt_after_reset", 32'd0);
    repeat (10) tick;
    rd(A_LO, "cnt_lo_10", 32'd10);
    rd(A_HI, "cnt_hi_10", 32'd0);

    // Counter wrap from all-ones
    force dut.cycle_q = 64'hFFFF_FFFF_FFFF_FFFF;
    rd(A_LO, "cnt_forced_lo", 32'hFFFF_FFFF);
    release dut.cycle_q;
    tick;
    rd(A_LO, "cnt_wrap_lo", 32'd0);
    rd(A_HI, "cnt_wrap_hi", 32'd0);

    // Directed vectors: one row per cycle, read reflects pre-edge state
    vt[0]  = '{32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0};
    vt[1]  = '{32'h0000_0102, 32'h0000_0055, 4'h1, 1'b1, 32'h0000_DEAD};
    vt[2]  = '{32'h0000_0100, 32'h0,         4'h0, 1'b1, 32'hDE55_BEEF};
    vt[3]  = '{32'h0000_0102, 32'h0,         4'h0, 1'b1, 32'h0000_DE55};
    vt[4]  = '{32'h0000_1100, 32'h0,         4'h0, 1'b1, 32'hDE55_BEEF};
    vt[5]  = '{32'h8000_0010, 32'h0,         4'h0, 1'b1, 32'h0};
    vt[6]  = '{32'h8000_0012, 32'h0000_ABCD, 4'h3, 1'b1, 32'h0};
    vt[7]  = '{32'h8000_0010, 32'h0,         4'h0, 1'b1, 32'hABCD_0000};
    vt[8]  = '{32'h8000_0014, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0};
    vt[9]  = '{32'h8000_0011, 32'h0,         4'h0, 1'b1, 32'h00AB_CD00};
    vt[10] = '{32'h9000_0110, 32'h0,         4'h0, 1'b1, 32'hABCD_0000};
    vt[11] = '{32'h8000_000C, 32'h0,         4'h0, 1'b1, 32'h0000_0002};
    vt[12] = '{32'h8000_0008, 32'h0000_0077, 4'h0, 1'b1, 32'h0};
    vt[13] = '{32'h8000_000C, 32'h0,         4'h0, 1'b1, 32'h0000_0002};
    vt[14] = '{32'h8000_0003, 32'h0,         4'h0, 1'b1, 32'h0};
    vt[15] = '{32'h8000_0050, 32'h0,         4'h0, 1'b1, 32'h0};
    vt[16] = '{32'h0000_0103, 32'h0000_A1B2, 4'h3, 1'b1, 32'h0000_00DE};
    vt[17] = '{32'h0000_0100, 32'h0,         4'h0, 1'b1, 32'hB255_BEEF};

    for (int i = 0; i < 18; i++) begin
      apply(vt[i].addr, vt[i].wd, vt[i].we, 1'b0);
      if (vt[i].chk) chk($sformatf("vec%0d_rd", i), drdata, vt[i].exp);
      chk($sformatf("vec%0d_txv", i), {31'b0, tx_valid}, 32'd0);
      tick;
    end

    // Fill to full, overflow, clear
    fill(8'h41, 8);
    rd(A_ST, "st_full", 32'h81);
    chk("full_txv", {31'b0, tx_valid}, 32'd1);
    chk("full_head", {24'b0, tx_data}, 32'h41);
    apply(A_TX, 32'h49, 4'b0001, 1'b0);
    tick;
    rd(A_ST, "st_ovf", 32'h85);
    apply(A_ST, 32'h4, 4'b0001, 1'b0);
    tick;
    rd(A_ST, "st_ovf_clr", 32'h81);

    // Drain in order at one byte per cycle
    apply(A_ST, 32'h0, 4'h0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d_v", i), {31'b0, tx_valid}, 32'd1);
      chk($sformatf("drain%0d_d", i), {24'b0, tx_data}, 32'(8'h41 + 8'(i)));
      tick;
    end
    chk("drain_end_v", {31'b0, tx_valid}, 32'd0);
    rd(A_ST, "st_empty", 32'h02);
    tx_ready = 1'b0;

    // Push and pop together while full
    fill(8'h41, 8);
    apply(A_TX, 32'h5A, 4'b0001, 1'b1);
    chk("pp_head", {24'b0, tx_data}, 32'h41);
    tick;
    apply(A_ST, 32'h0, 4'h0, 1'b0);
    chk("pp_status", drdata, 32'h81);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("pp_drain%0d", i), {24'b0, tx_data}, (i < 7) ? 32'(8'h42 + 8'(i)) : 32'h5A);
      tick;
    end
    chk("pp_end_v", {31'b0, tx_valid}, 32'd0);
    tx_ready = 1'b0;

    // Reset in the middle of a stream
    fill(8'h61, 3);
    apply(A_SC, 32'h1234, 4'hF, 1'b0);
    tick;
    rd(A_SC, "scr_pre_rst", 32'h1234);
    chk("txv_pre_rst", {31'b0, tx_valid}, 32'd1);
    reset = 1'b1;
    apply(32'h0000_0100, 32'h0BAD_F00D, 4'hF, 1'b0);
    tick;
    reset = 1'b0;
    chk("rst_txv", {31'b0, tx_valid}, 32'd0);
    chk("rst_txd", {24'b0, tx_data}, 32'd0);
    rd(A_ST, "rst_status", 32'h02);
    rd(A_SC, "rst_scratch", 32'h0);
    rd(A_LO, "rst_cnt", 32'h0);
    rd(32'h0000_0100, "rst_ram", 32'hB255_BEEF);

    // Random traffic against the behavioural model
    reset = 1'b1;
    apply(32'h0, 32'h0, 4'h0, 1'b0);
    tick;
    reset = 1'b0;
    mcnt = 64'd0; mscr = 32'h0; movf = 1'b0; mq.delete();
    for (int w = 0; w < 16; w++) begin
      mram[w] = $urandom;
      apply({1'b0, 19'($urandom), 6'd0, 4'(w), 2'b00}, mram[w], 4'hF, 1'b0);
      tick;
      mcnt = mcnt + 64'd1;
    end

    for (int n = 0; n < 400; n++) begin
      int          kind;
      int          idx;
      int          o;
      logic [1:0]  off;
      logic [3:0]  we;
      logic [3:0]  mask;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] sd;
      logic [31:0] exp_word;
      logic        rdy;

      kind = $urandom_range(0, 5);
      off  = 2'($urandom);
      d    = $urandom;
      rdy  = 1'($urandom);
      idx  = $urandom_range(0, 15);
      case ($urandom_range(0, 3))
        0:       we = 4'h0;
        1:       we = 4'h1;
        2:       we = 4'h3;
        default: we = 4'hF;
      endcase
      if (kind == 1 && $urandom_range(0, 1) == 1) off = 2'b00;

      o = 0;
      exp_word = 32'h0;
      case (kind)
        0: exp_word = mram[idx];
        1: begin o = 2; exp_word = 32'h0; end
        2: begin
          o = 3;
          exp_word = 32'h0;
          exp_word[0]   = (mq.size() == FIFO_DEPTH);
          exp_word[1]   = (mq.size() == 0);
          exp_word[2]   = movf;
          exp_word[8:4] = 5'(mq.size());
        end
        3: begin o = 4; exp_word = mscr; end
        4: begin
          o = $urandom_range(0, 1);
          exp_word = (o == 0) ? mcnt[31:0] : mcnt[63:32];
        end
        default: begin o = $urandom_range(5, 63); exp_word = 32'h0; end
      endcase

      if (kind == 0) a = {1'b0, 19'($urandom), 6'd0, 4'(idx), off};
      else           a = {1'b1, 23'($urandom), 6'(o), off};

      apply(a, d, we, rdy);
      chk("rnd_rd", drdata, exp_word >> (8 * off));
      chk("rnd_txv", {31'b0, tx_valid}, {31'b0, mq.size() != 0});
      chk("rnd_txd", {24'b0, tx_data}, (mq.size() != 0) ? {24'b0, mq[0]} : 32'h0);
      tick;

      mask = 4'(we << off);
      sd   = d << (8 * off);
      if (mq.size() != 0 && rdy) void'(mq.pop_front());
      case (kind)
        0: for (int l = 0; l < 4; l++) if (mask[l]) mram[idx][8*l +: 8] = sd[8*l +: 8];
        1: if (mask[0]) begin
             if (mq.size() < FIFO_DEPTH) mq.push_back(sd[7:0]);
             else movf = 1'b1;
           end
        2: if (mask[0] && sd[2]) movf = 1'b0;
        3: for (int l = 0; l < 4; l++) if (mask[l]) mscr[8*l +: 8] = sd[8*l +: 8];
        default: ;
      endcase
      mcnt = mcnt + 64'd1;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
